// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: tracks EX/MEM/WB destinations,
// raises stall/flush/bubble, ID-stage WB bypass and registered EX forwarding selects.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              ex_redirect_i,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              id_byp_a_o,
  output logic              id_byp_b_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              ex_valid, ex_regwrite, ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_valid, mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_regwrite;
  logic [REG_AW-1:0] wb_rd;

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic hazard, stall, redirect;

  // Register 0 is hard-wired, so a zero source never depends on a producer.
  function automatic logic src_match(input logic              use_src,
                                     input logic [REG_AW-1:0] src,
                                     input logic              stg_valid,
                                     input logic              stg_rw,
                                     input logic [REG_AW-1:0] stg_rd);
    return use_src && stg_valid && stg_rw && (stg_rd == src) && (src != '0);
  endfunction

  always_comb begin
    ex_a  = id_valid_i && src_match(id_use_rs_i, id_rs_i, ex_valid,  ex_regwrite,  ex_rd);
    ex_b  = id_valid_i && src_match(id_use_rt_i, id_rt_i, ex_valid,  ex_regwrite,  ex_rd);
    mem_a = id_valid_i && src_match(id_use_rs_i, id_rs_i, mem_valid, mem_regwrite, mem_rd);
    mem_b = id_valid_i && src_match(id_use_rt_i, id_rt_i, mem_valid, mem_regwrite, mem_rd);
    wb_a  = id_valid_i && src_match(id_use_rs_i, id_rs_i, wb_valid,  wb_regwrite,  wb_rd);
    wb_b  = id_valid_i && src_match(id_use_rt_i, id_rt_i, wb_valid,  wb_regwrite,  wb_rd);

    if (FWD_EN != 0)
      hazard = ex_memread && (ex_a || ex_b);
    else
      hazard = ex_a || ex_b || mem_a || mem_b;

    // A taken redirect squashes the stalled instruction, so it wins over the stall.
    redirect = rst_n && ex_redirect_i;
    stall    = rst_n && hazard && !ex_redirect_i;

    pc_stall_o    = stall;
    ifid_stall_o  = stall;
    ifid_flush_o  = redirect;
    idex_bubble_o = stall || redirect;
    id_byp_a_o    = rst_n && wb_a;
    id_byp_b_o    = rst_n && wb_b;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
      fwd_a_o      <= '0;
      fwd_b_o      <= '0;
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
    end else begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;

      if (idex_bubble_o || !id_valid_i) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_rd       <= '0;
        fwd_a_o     <= '0;
        fwd_b_o     <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_regwrite <= id_regwrite_i;
        ex_memread  <= id_memread_i;
        ex_rd       <= id_rd_i;
        // Selects are captured with the instruction so EX sees them with no extra logic.
        if (FWD_EN != 0) begin
          fwd_a_o <= ex_a ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
          fwd_b_o <= ex_b ? 2'b01 : (mem_b ? 2'b10 : 2'b00);
        end else begin
          fwd_a_o <= '0;
          fwd_b_o <= '0;
        end
      end

      if (pc_stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding instance driven from a vector table,
// stall-only and saturating-counter instances exercised by hand-written sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v, urs, urt, rw, mr, redir;
  logic [4:0] rs, rt, rd;

  logic       f_pcs, f_ifs, f_fl, f_bub, f_ba, f_bb;
  logic [1:0] f_fa, f_fb;
  logic [15:0] f_sc, f_fc;
  logic       s_pcs, s_ifs, s_fl, s_bub, s_ba, s_bb;
  logic [1:0] s_fa, s_fb;
  logic [15:0] s_sc, s_fc;
  logic       t_pcs, t_ifs, t_fl, t_bub, t_ba, t_bb;
  logic [1:0] t_fa, t_fb;
  logic [1:0] t_sc, t_fc;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk_i(clk), .rst_n(rst_n), .id_valid_i(v), .id_rs_i(rs), .id_rt_i(rt),
    .id_use_rs_i(urs), .id_use_rt_i(urt), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr), .ex_redirect_i(redir), .pc_stall_o(f_pcs), .ifid_stall_o(f_ifs),
    .ifid_flush_o(f_fl), .idex_bubble_o(f_bub), .id_byp_a_o(f_ba), .id_byp_b_o(f_bb),
    .fwd_a_o(f_fa), .fwd_b_o(f_fb), .stall_cnt_o(f_sc), .flush_cnt_o(f_fc));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) u_stl (
    .clk_i(clk), .rst_n(rst_n), .id_valid_i(v), .id_rs_i(rs), .id_rt_i(rt),
    .id_use_rs_i(urs), .id_use_rt_i(urt), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr), .ex_redirect_i(redir), .pc_stall_o(s_pcs), .ifid_stall_o(s_ifs),
    .ifid_flush_o(s_fl), .idex_bubble_o(s_bub), .id_byp_a_o(s_ba), .id_byp_b_o(s_bb),
    .fwd_a_o(s_fa), .fwd_b_o(s_fb), .stall_cnt_o(s_sc), .flush_cnt_o(s_fc));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_n(rst_n), .id_valid_i(v), .id_rs_i(rs), .id_rt_i(rt),
    .id_use_rs_i(urs), .id_use_rt_i(urt), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr), .ex_redirect_i(redir), .pc_stall_o(t_pcs), .ifid_stall_o(t_ifs),
    .ifid_flush_o(t_fl), .idex_bubble_o(t_bub), .id_byp_a_o(t_ba), .id_byp_b_o(t_bb),
    .fwd_a_o(t_fa), .fwd_b_o(t_fb), .stall_cnt_o(t_sc), .flush_cnt_o(t_fc));

  typedef struct {
    logic v, urs, urt, rw, mr, redir;
    logic [4:0] rs, rt, rd;
    logic st, fl, ba, bb;
    logic [1:0] fa, fb;
    int sc, fc;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic v_, input int rs_, input int rt_, input logic urs_,
                              input logic urt_, input int rd_, input logic rw_, input logic mr_,
                              input logic rdr_, input logic st_, input logic fl_, input logic ba_,
                              input logic bb_, input int fa_, input int fb_, input int sc_,
                              input int fc_);
    vec_t r;
    r.v = v_; r.rs = 5'(rs_); r.rt = 5'(rt_); r.urs = urs_; r.urt = urt_; r.rd = 5'(rd_);
    r.rw = rw_; r.mr = mr_; r.redir = rdr_; r.st = st_; r.fl = fl_; r.ba = ba_; r.bb = bb_;
    r.fa = 2'(fa_); r.fb = 2'(fb_); r.sc = sc_; r.fc = fc_;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v_, input int rs_, input int rt_, input logic urs_,
                       input logic urt_, input int rd_, input logic rw_, input logic mr_,
                       input logic rdr_);
    v = v_; rs = 5'(rs_); rt = 5'(rt_); urs = urs_; urt = urt_; rd = 5'(rd_);
    rw = rw_; mr = mr_; redir = rdr_;
  endtask

  task automatic chk_stl(input string nm, input logic st, input logic ba);
    chk({nm, " stl pc_stall"}, int'(s_pcs), int'(st));
    chk({nm, " stl ifid_stall"}, int'(s_ifs), int'(st));
    chk({nm, " stl bubble"}, int'(s_bub), int'(st));
    chk({nm, " stl flush"}, int'(s_fl), 0);
    chk({nm, " stl byp_a"}, int'(s_ba), int'(ba));
    chk({nm, " stl byp_b"}, int'(s_bb), 0);
    chk({nm, " stl fwd_a"}, int'(s_fa), 0);
    chk({nm, " stl fwd_b"}, int'(s_fb), 0);
  endtask

  task automatic chk_comb_zero(input string nm);
    chk({nm, " pc_stall"}, int'(f_pcs | s_pcs | t_pcs), 0);
    chk({nm, " ifid_stall"}, int'(f_ifs | s_ifs | t_ifs), 0);
    chk({nm, " flush"}, int'(f_fl | s_fl | t_fl), 0);
    chk({nm, " bubble"}, int'(f_bub | s_bub | t_bub), 0);
    chk({nm, " byp"}, int'(f_ba | f_bb | s_ba | s_bb), 0);
  endtask

  initial begin
    // rd=3 add, r3 consumer, lw r2 / r2 consumer, r0 case, load-use+redirect, youngest-wins
    tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 2, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 2, 2, 1, 1, 6, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 2, 2, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 1, 0);
    tbl[7]  = mk(1, 1, 1, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(1, 1, 0, 1, 0, 9, 1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(1, 9, 7, 1, 1, 10, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);
    tbl[12] = mk(1, 9, 7, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[13] = mk(0, 9, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1, 1);
    tbl[14] = mk(1, 1, 1, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1);
    tbl[15] = mk(1, 5, 1, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(1, 5, 5, 1, 1, 8, 1, 0, 0,  0, 0, 0, 0, 1, 0, 1, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1);

    // Reset with hazard-provoking inputs: combinational outputs must stay low.
    rst_n = 1'b0;
    drive(1, 3, 3, 1, 1, 3, 1, 1, 1);
    repeat (2) @(negedge clk);
    #1 chk_comb_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post-reset fwd", int'({f_fa, f_fb}), 0);
    chk("post-reset stall_cnt", int'(f_sc), 0);
    chk("post-reset flush_cnt", int'(f_fc), 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].v, int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].urs, tbl[i].urt,
            int'(tbl[i].rd), tbl[i].rw, tbl[i].mr, tbl[i].redir);
      #1;
      chk($sformatf("row%0d pc_stall", i), int'(f_pcs), int'(tbl[i].st));
      chk($sformatf("row%0d ifid_stall", i), int'(f_ifs), int'(tbl[i].st));
      chk($sformatf("row%0d flush", i), int'(f_fl), int'(tbl[i].fl));
      chk($sformatf("row%0d bubble", i), int'(f_bub), int'(tbl[i].st | tbl[i].fl));
      chk($sformatf("row%0d byp_a", i), int'(f_ba), int'(tbl[i].ba));
      chk($sformatf("row%0d byp_b", i), int'(f_bb), int'(tbl[i].bb));
      chk($sformatf("row%0d fwd_a", i), int'(f_fa), int'(tbl[i].fa));
      chk($sformatf("row%0d fwd_b", i), int'(f_fb), int'(tbl[i].fb));
      chk($sformatf("row%0d stall_cnt", i), int'(f_sc), tbl[i].sc);
      chk($sformatf("row%0d flush_cnt", i), int'(f_fc), tbl[i].fc);
    end

    // Stall-only instances: three rounds of add r3 ; sub r7,r3,r1.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
      #1 chk_stl($sformatf("r%0d producer", k), 0, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        drive(1, 3, 1, 1, 1, 7, 1, 0, 0);
        #1 chk_stl($sformatf("r%0d consumer c%0d", k, c), (c < 2), (c == 2));
      end
      chk($sformatf("r%0d stl stall_cnt", k), int'(s_sc), 2 * k);
      chk($sformatf("r%0d sat stall_cnt", k), int'(t_sc), (2 * k > 3) ? 3 : 2 * k);
    end

    // Reset arriving while a stall is active.
    @(negedge clk);
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
    @(negedge clk);
    drive(1, 3, 1, 1, 1, 7, 1, 0, 0);
    #1 chk_stl("pre-reset stall", 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 3, 1, 1, 1, 7, 1, 0, 1);
    #1 chk_comb_zero("mid-stall reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3, 1, 1, 1, 7, 1, 0, 0);
    #1;
    chk_stl("after reset", 0, 0);
    chk("after reset stl stall_cnt", int'(s_sc), 0);
    chk("after reset sat stall_cnt", int'(t_sc), 0);
    chk("after reset fwd flush_cnt", int'(f_fc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- REG_AW, default 5, register-address width.
- FWD_EN, default 1; 1 = forwarding mode, 0 = stall-only mode.
- CNT_W, default 16, width of the performance counters.

REQ-002 Ports SHALL be:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  REG_AW  ID source register A.
- id_rt_i  in  REG_AW  ID source register B.
- id_use_rs_i  in  1  ID instruction reads rs.
- id_use_rt_i  in  1  ID instruction reads rt.
- id_rd_i  in  REG_AW  ID final destination register (after RegDst/link selection).
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- ex_redirect_i  in  1  branch/jump/jr resolved taken in EX this cycle.
- pc_stall_o  out  1  hold PC.
- ifid_stall_o  out  1  hold IF/ID register.
- ifid_flush_o  out  1  load NOP into IF/ID.
- idex_bubble_o  out  1  load NOP (all control zero) into ID/EX.
- id_byp_a_o  out  1  ID/EX rs capture takes the WB write data.
- id_byp_b_o  out  1  ID/EX rt capture takes the WB write data.
- fwd_a_o  out  2  EX operand A select: 00 ID/EX, 01 EX/MEM result, 10 MEM/WB write data.
- fwd_b_o  out  2  EX operand B select, same encoding.
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1.
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1.

Function
REQ-003 Block SHALL track three in-flight stages (EX, MEM, WB), each holding valid, rd, regwrite, memread; each clock WB<=MEM, MEM<=EX, EX<=ID info, or all-zero when idex_bubble_o=1 or id_valid_i=0.
REQ-004 A source SHALL match a stage only when its use bit is 1, the stage is valid with regwrite=1, stage rd equals the source, and the source is nonzero; register 0 SHALL never match.
REQ-005 In FWD_EN=1, a load-use hazard (EX stage has memread=1 and matches an ID source) SHALL assert pc_stall_o, ifid_stall_o and idex_bubble_o for exactly one cycle.
REQ-006 In FWD_EN=1, fwd_a_o/fwd_b_o SHALL be registered: computed at the ID->EX transfer from the then-EX match (01), else the then-MEM match (10), else 00; youngest producer wins; bubbles SHALL load 00.
REQ-007 id_byp_a_o/id_byp_b_o SHALL be combinational: 1 when the WB stage matches the ID source, in both modes; the register file has no internal write-through.
REQ-008 In FWD_EN=0, stall (pc_stall_o, ifid_stall_o, idex_bubble_o) SHALL hold while the EX or MEM stage matches an ID source, giving at most 2 stall cycles; fwd outputs SHALL stay 00.
REQ-009 ex_redirect_i=1 SHALL assert ifid_flush_o and idex_bubble_o and SHALL force pc_stall_o=ifid_stall_o=0 in the same cycle; redirect SHALL override stall.
REQ-010 id_valid_i=0 SHALL suppress all hazard detection for that cycle.
REQ-011 Hazard outputs (pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, id_byp_*) SHALL be combinational from current state and inputs, with zero-cycle latency.
REQ-012 Each counter SHALL increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 (no wrap).

Reset
REQ-013 While rst_n=0 at a clock edge, the block SHALL clear all stage valid bits, fwd_a_o, fwd_b_o, stall_cnt_o and flush_cnt_o to 0.
REQ-014 During reset, the block SHALL drive all combinational hazard outputs to 0, regardless of inputs.
REQ-015 Reset asserted mid-stall SHALL drop stall in the cycle after the reset edge.

Verification
REQ-016 FWD_EN=1: add r3 then add r4,r3,r5 back-to-back -> no stall; fwd_a_o=01 in consumer's EX cycle.
REQ-017 FWD_EN=1: lw r2 then add r6,r2,r2 -> exactly 1 stall cycle with bubble; consumer then sees fwd_a_o=fwd_b_o=10; stall_cnt_o=1.
REQ-018 FWD_EN=0: add r3 then sub r7,r3,r1 -> 2 stall cycles, then id_byp_a_o=1 on the issue cycle; stall_cnt_o=2.
REQ-019 Producer writes r0, consumer reads r0 -> no stall, fwd 00, no bypass.
REQ-020 Load-use stall coinciding with ex_redirect_i=1 -> pc_stall_o=0, ifid_flush_o=1, idex_bubble_o=1; flush_cnt_o increments by 1.
REQ-021 CNT_W=2 with 5 consecutive stall cycles -> stall_cnt_o holds at 3.
